hyperbus_delay_ctrl: RTL and testbench

HYPERBUS_DELAY_CTRL -- requirements
Module: hyperbus_delay_ctrl

---
 rtl/hyperbus_pkg.sv | 23 ++
 rtl/hyperbus_delay_ctrl_cnt.sv | 33 +++
 rtl/hyperbus_delay_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_hyperbus_delay_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperbus_pkg.sv
// Shared definitions for the HyperBus delay-line controller: FSM state
// encoding, timer width and the tap-width helper.
package hyperbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_GATE_OFF,
    ST_UPDATE,
    ST_GATE_ON,
    ST_SAMPLE,
    ST_FINISH
  } state_e;

  // Width of the settle/sample timer; comfortably covers any dwell count.
  localparam int CNT_W = 16;

  // Number of select bits needed to address num_taps delay-line taps.
  function automatic int tap_width(input int num_taps);
    return (num_taps > 1) ? $clog2(num_taps) : 1;
  endfunction

endpackage

// File: rtl/hyperbus_delay_ctrl_cnt.sv
// Loadable down-counter with a zero flag. Shared by the settle timer
// (gate off / gate on) and the training dwell timer.
module hyperbus_delay_ctrl_cnt
  import hyperbus_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;

  // Load has priority; decrement stops at zero so the flag stays asserted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: clocked state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hyperbus_delay_ctrl.sv
// HyperBus delay-line tap controller. Every tap change is wrapped in a gated
// sequence (wait for idle bus, gate off, settle, switch tap, settle, gate on)
// so the delay mux select never moves while the strobe path is enabled.
// A training sweep visits every tap, records a pass mask and settles on the
// centre of the passing window.
module hyperbus_delay_ctrl
  import hyperbus_pkg::*;
#(
  parameter int NUM_TAPS      = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLE_CYCLES = 8,
  parameter int DEFAULT_TAP   = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_valid_i,
  input  logic [31:0] cfg_delay_i,
  output logic        cfg_ready_o,
  input  logic        train_start_i,
  input  logic        train_pass_i,
  input  logic        phy_idle_i,
  output logic        gate_en_o,
  output logic [31:0] delay_o,
  output logic        busy_o,
  output logic        train_done_o,
  output logic        train_ok_o
);

  localparam int                 TAP_W     = tap_width(NUM_TAPS);
  localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SAMPLE_LD = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [TAP_W-1:0]   LAST_TAP  = TAP_W'(NUM_TAPS - 1);
  localparam logic [TAP_W-1:0]   DEF_TAP   = TAP_W'(DEFAULT_TAP);

  state_e              state_q;
  logic [TAP_W-1:0]    delay_q;      // tap currently driven to the delay line
  logic [TAP_W-1:0]    target_q;     // tap to apply in the next UPDATE
  logic [TAP_W-1:0]    saved_q;      // tap in use when training started
  logic [TAP_W-1:0]    tap_idx_q;    // tap under test during the sweep
  logic [NUM_TAPS-1:0] mask_q;       // per-tap training result
  logic                training_q;   // sweep in progress
  logic                final_q;      // applying the post-training tap
  logic                gate_q;
  logic                done_q;
  logic                ok_q;

  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_load_val;
  logic                cnt_dec;
  logic                cnt_zero;

  logic [TAP_W-1:0]    lo_tap;
  logic [TAP_W-1:0]    hi_tap;
  logic [TAP_W:0]      tap_sum;
  logic                any_pass_d;
  logic [TAP_W-1:0]    best_tap_d;

  // Only the tap-select bits of the request are meaningful.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfg_delay_i[31:TAP_W];

  hyperbus_delay_ctrl_cnt #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Centre of the passing window, or the pre-training tap if nothing passed.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    lo_tap     = '0;
    hi_tap     = '0;
    any_pass_d = 1'b0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (mask_q[i]) begin
        if (!any_pass_d) lo_tap = TAP_W'(i);
        hi_tap     = TAP_W'(i);
        any_pass_d = 1'b1;
      end
    end
    tap_sum    = {1'b0, lo_tap} + {1'b0, hi_tap};
    best_tap_d = any_pass_d ? tap_sum[TAP_W:1] : saved_q;
  end

  // Timer control: load on entry to each timed state, count down inside it.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = SETTLE_LD;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_WAIT_IDLE: cnt_load = phy_idle_i;
      ST_UPDATE:    cnt_load = 1'b1;
      ST_GATE_ON: begin
        if (cnt_zero && training_q && !final_q) begin
          cnt_load     = 1'b1;
          cnt_load_val = SAMPLE_LD;
        end else begin
          cnt_dec = !cnt_zero;
        end
      end
      ST_GATE_OFF,
      ST_SAMPLE:    cnt_dec = !cnt_zero;
      default:      ;
    endcase
  end

  // Main sequencer with registered gate/tap/result outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      delay_q    <= DEF_TAP;
      target_q   <= DEF_TAP;
      saved_q    <= DEF_TAP;
      tap_idx_q  <= '0;
      // NOTE: the pass mask is a handful of flops, not a RAM, so it is
      // cleared by reset like any other control state.
      mask_q     <= '0;
      training_q <= 1'b0;
      final_q    <= 1'b0;
      gate_q     <= 1'b1;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Training wins over a simultaneous request, which stays pending.
          if (train_start_i) begin
            training_q <= 1'b1;
            final_q    <= 1'b0;
            tap_idx_q  <= '0;
            target_q   <= '0;
            saved_q    <= delay_q;
            mask_q     <= '0;
            state_q    <= ST_WAIT_IDLE;
          end else if (cfg_valid_i) begin
            training_q <= 1'b0;
            final_q    <= 1'b0;
            target_q   <= cfg_delay_i[TAP_W-1:0];
            state_q    <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (phy_idle_i) begin
            gate_q  <= 1'b0;
            state_q <= ST_GATE_OFF;
          end
        end
        ST_GATE_OFF: begin
          if (cnt_zero) begin
            delay_q <= target_q;
            state_q <= ST_UPDATE;
          end
        end
        ST_UPDATE: state_q <= ST_GATE_ON;
        ST_GATE_ON: begin
          if (cnt_zero) begin
            gate_q <= 1'b1;
            if (training_q && !final_q) begin
              state_q <= ST_SAMPLE;
            end else begin
              done_q     <= final_q;
              training_q <= 1'b0;
              final_q    <= 1'b0;
              state_q    <= ST_IDLE;
            end
          end
        end
        ST_SAMPLE: begin
          if (cnt_zero) begin
            mask_q[tap_idx_q] <= train_pass_i;
            if (tap_idx_q == LAST_TAP) begin
              state_q <= ST_FINISH;
            end else begin
              tap_idx_q <= tap_idx_q + 1'b1;
              target_q  <= tap_idx_q + 1'b1;
              state_q   <= ST_WAIT_IDLE;
            end
          end
        end
        ST_FINISH: begin
          target_q <= best_tap_d;
          ok_q     <= any_pass_d;
          final_q  <= 1'b1;
          state_q  <= ST_WAIT_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready_o  = (state_q == ST_IDLE) && !train_start_i;
  assign busy_o       = (state_q != ST_IDLE);
  assign gate_en_o    = gate_q;
  assign delay_o      = {{(32 - TAP_W){1'b0}}, delay_q};
  assign train_done_o = done_q;
  assign train_ok_o   = ok_q;

endmodule

// File: tb/tb_hyperbus_delay_ctrl.sv
// Self-checking bench for hyperbus_delay_ctrl: a sequential behavioural model
// of the gated tap-change and training procedure runs alongside the DUT and is
// compared every cycle; directed scenarios pin literal expectations.
module tb_hyperbus_delay_ctrl;

  localparam int NUM_TAPS      = 4;
  localparam int SETTLE_CYCLES = 4;
  localparam int SAMPLE_CYCLES = 8;
  localparam int DEFAULT_TAP   = 0;
  localparam int TW            = $clog2(NUM_TAPS);

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic [31:0] cfg_delay;
  logic        cfg_ready;
  logic        train_start;
  logic        train_pass;
  logic        phy_idle;
  logic        gate_en;
  logic [31:0] delay;
  logic        busy;
  logic        train_done;
  logic        train_ok;

  // PHY stand-in: either a per-tap pass pattern or a free random bit.
  logic                use_pat;
  logic [NUM_TAPS-1:0] pass_pat;
  logic                pass_rand;
  assign train_pass = use_pat ? pass_pat[delay[TW-1:0]] : pass_rand;

  int n_vec = 0;
  int n_err = 0;

  // Model outputs
  logic [TW-1:0] m_tap;
  logic          m_gate;
  logic          m_busy;
  logic          m_done;
  logic          m_ok;
  logic          m_abort;

  hyperbus_delay_ctrl #(
    .NUM_TAPS      (NUM_TAPS),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .SAMPLE_CYCLES (SAMPLE_CYCLES),
    .DEFAULT_TAP   (DEFAULT_TAP)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cfg_valid_i   (cfg_valid),
    .cfg_delay_i   (cfg_delay),
    .cfg_ready_o   (cfg_ready),
    .train_start_i (train_start),
    .train_pass_i  (train_pass),
    .phy_idle_i    (phy_idle),
    .gate_en_o     (gate_en),
    .delay_o       (delay),
    .busy_o        (busy),
    .train_done_o  (train_done),
    .train_ok_o    (train_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  task automatic m_init();
    m_tap   = TW'(DEFAULT_TAP);
    m_gate  = 1'b1;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_ok    = 1'b0;
    m_abort = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) m_abort = 1'b1;
    m_done = 1'b0;
  endtask

  // Wait for an idle bus, then gate off for the settle time, switch the tap,
  // settle again and re-enable the gate.
  task automatic gated_update(input logic [TW-1:0] tap);
    do begin
      tick();
      if (m_abort) return;
    end while (!phy_idle);
    m_gate = 1'b0;
    for (int i = 0; i < SETTLE_CYCLES; i++) begin
      tick();
      if (m_abort) return;
    end
    m_tap = tap;
    tick();
    if (m_abort) return;
    for (int i = 0; i < SETTLE_CYCLES; i++) begin
      tick();
      if (m_abort) return;
    end
    m_gate = 1'b1;
  endtask

  task automatic training();
    logic [TW-1:0]       saved;
    logic [NUM_TAPS-1:0] mask;
    int                  lo;
    int                  hi;
    saved = m_tap;
    mask  = '0;
    lo    = -1;
    hi    = -1;
    for (int t = 0; t < NUM_TAPS; t++) begin
      gated_update(TW'(t));
      if (m_abort) return;
      for (int i = 0; i < SAMPLE_CYCLES; i++) begin
        tick();
        if (m_abort) return;
      end
      mask[t] = train_pass;
    end
    tick();
    if (m_abort) return;
    for (int t = 0; t < NUM_TAPS; t++) begin
      if (mask[t]) begin
        if (lo < 0) lo = t;
        hi = t;
      end
    end
    m_ok = (lo >= 0);
    gated_update((lo >= 0) ? TW'((lo + hi) / 2) : saved);
    if (m_abort) return;
    m_busy = 1'b0;
    m_done = 1'b1;
  endtask

  task automatic model_loop();
    forever begin
      tick();
      if (!m_abort) begin
        if (train_start) begin
          m_busy = 1'b1;
          training();
        end else if (cfg_valid) begin
          m_busy = 1'b1;
          gated_update(cfg_delay[TW-1:0]);
          if (!m_abort) m_busy = 1'b0;
        end
      end
      if (m_abort) m_init();
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_gate", {31'd0, gate_en}, 32'd1);
        check("rst_delay", delay, DEFAULT_TAP);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, cfg_ready}, {31'd0, !train_start});
        check("rst_done", {31'd0, train_done}, 32'd0);
        check("rst_ok", {31'd0, train_ok}, 32'd0);
      end else begin
        check("gate", {31'd0, gate_en}, {31'd0, m_gate});
        check("delay", delay, {{(32 - TW){1'b0}}, m_tap});
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("ready", {31'd0, cfg_ready}, {31'd0, (!m_busy && !train_start)});
        check("done", {31'd0, train_done}, {31'd0, m_done});
        check("ok", {31'd0, train_ok}, {31'd0, m_ok});
      end
    end
  endtask

  // Observe until the DUT returns to idle; counts busy and gate-low cycles,
  // completion pulses and the first cycle at which delay_o moved.
  task automatic run_to_idle(input int max, output int n_busy, output int n_gl,
                             output int n_done, output int k_chg);
    logic [31:0] start_delay;
    start_delay = delay;
    n_busy = 0;
    n_gl   = 0;
    n_done = 0;
    k_chg  = -1;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if (train_done) n_done++;
      if (!gate_en) n_gl++;
      if ((delay != start_delay) && (k_chg < 0)) k_chg = k;
      if (!busy) break;
      n_busy++;
    end
    check("idle_within_budget", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] d);
    cfg_valid = 1'b1;
    cfg_delay = d;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int nb, ngl, nd, kc, bad;
    rst         = 1'b1;
    cfg_valid   = 1'b0;
    cfg_delay   = '0;
    train_start = 1'b0;
    phy_idle    = 1'b1;
    pass_rand   = 1'b0;
    use_pat     = 1'b0;
    pass_pat    = '0;
    m_init();
    fork
      model_loop();
      compare_loop();
    join_none

    // Reset values
    #2;
    check("reset_delay", delay, 32'd0);
    check("reset_gate", {31'd0, gate_en}, 32'd1);
    check("reset_ready", {31'd0, cfg_ready}, 32'd1);
    step();
    step();
    rst = 1'b0;
    step();

    // Plain update to tap 2 with an idle bus
    request(32'd2);
    run_to_idle(40, nb, ngl, nd, kc);
    check("upd2_busy_cycles", nb, 32'd10);
    check("upd2_gate_low_cycles", ngl, 32'd9);
    check("upd2_delay_change_cycle", kc, 32'd6);
    check("upd2_delay", delay, 32'd2);

    // Busy PHY holds everything off
    phy_idle = 1'b0;
    request(32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gate_en !== 1'b1 || delay !== 32'd2) bad++;
    end
    check("hold_while_phy_busy", bad, 32'd0);
    @(posedge clk);
    #1;
    phy_idle = 1'b1;
    run_to_idle(40, nb, ngl, nd, kc);
    check("after_phy_idle_gate_low", ngl, 32'd9);
    check("after_phy_idle_delay", delay, 32'd1);

    // Truncation: 7 -> tap 3
    request(32'd7);
    run_to_idle(40, nb, ngl, nd, kc);
    check("trunc7_delay", delay, 32'd3);

    // Training with no passes keeps the prior tap
    use_pat     = 1'b1;
    pass_pat    = 4'b0000;
    train_start = 1'b1;
    step();
    train_start = 1'b0;
    run_to_idle(300, nb, ngl, nd, kc);
    check("nopass_delay", delay, 32'd3);
    check("nopass_ok", {31'd0, train_ok}, 32'd0);
    check("nopass_done_pulses", nd, 32'd1);

    // Truncation: 5 -> tap 1
    request(32'd5);
    run_to_idle(40, nb, ngl, nd, kc);
    check("trunc5_delay", delay, 32'd1);

    // Training with passes on taps 1..3 picks tap 2
    pass_pat    = 4'b1110;
    train_start = 1'b1;
    step();
    train_start = 1'b0;
    run_to_idle(300, nb, ngl, nd, kc);
    check("pass123_delay", delay, 32'd2);
    check("pass123_ok", {31'd0, train_ok}, 32'd1);
    check("pass123_done_pulses", nd, 32'd1);

    // Same-tap request still runs the full gated sequence
    request(32'd2);
    run_to_idle(40, nb, ngl, nd, kc);
    check("same_tap_busy_cycles", nb, 32'd10);
    check("same_tap_gate_low", ngl, 32'd9);

    // Reset in GATE_OFF aborts at once
    request(32'd3);
    step();
    step();
    check("in_gate_off", {31'd0, gate_en}, 32'd0);
    rst = 1'b1;
    #1;
    check("abort_delay", delay, 32'd0);
    check("abort_gate", {31'd0, gate_en}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ok", {31'd0, train_ok}, 32'd0);
    step();
    step();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (train_done !== 1'b0) bad++;
    end
    check("abort_no_done", bad, 32'd0);
    @(posedge clk);
    #1;

    // Simultaneous request and training: training wins, request waits
    pass_pat    = 4'b0001;
    cfg_valid   = 1'b1;
    cfg_delay   = 32'd3;
    train_start = 1'b1;
    #1;
    check("simul_ready_low", {31'd0, cfg_ready}, 32'd0);
    step();
    train_start = 1'b0;
    run_to_idle(300, nb, ngl, nd, kc);
    check("simul_train_delay", delay, 32'd0);
    check("simul_done_pulses", nd, 32'd1);
    cfg_valid = 1'b0;
    run_to_idle(40, nb, ngl, nd, kc);
    check("simul_pending_applied", delay, 32'd3);

    // Randomised traffic against the model
    use_pat = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      phy_idle    = ($urandom_range(0, 9) != 0);
      pass_rand   = 1'($urandom_range(0, 1));
      train_start = ($urandom_range(0, 99) < 2);
      if (!cfg_valid) begin
        cfg_valid = ($urandom_range(0, 3) == 0);
        cfg_delay = $urandom;
      end else if ($urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b0;
      end
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst         = 1'b0;
    cfg_valid   = 1'b0;
    train_start = 1'b0;
    phy_idle    = 1'b1;
    step();
    run_to_idle(400, nb, ngl, nd, kc);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
